mem_write_checker: RTL and testbench

- Synthesizable result checker on the write side of the 8-bit multicycle MIPS memory system (mips_mem).
- Snoops the CPU store bus (memwrite/adr/writedata) and logs every store in a small FIFO.
- Issues a sticky pass/fail/timeout verdict on the store to the designated result address, so self-checks work in simulation and on a board.

---
 rtl/mem_write_checker.sv | 125 ++++++++++++
 tb/tb_mem_write_checker.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_write_checker.sv
// Store-bus snooper for the multicycle MIPS memory system: logs stores in a
// small FIFO and issues a sticky pass/fail/timeout verdict on the result store.
module mem_write_checker #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] EXP_ADR  = 8'hEE,
    parameter logic [WIDTH-1:0] EXP_DATA = 8'h0D,
    parameter int               TIMEOUT  = 400,
    parameter int               LOGDEPTH = 2,
    parameter int               CNTW     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memwrite,
    input  logic [WIDTH-1:0] adr,
    input  logic [WIDTH-1:0] writedata,
    input  logic             log_rd,
    output logic             log_valid,
    output logic [WIDTH-1:0] log_adr,
    output logic [WIDTH-1:0] log_data,
    output logic             log_overflow,
    output logic [CNTW-1:0]  store_count,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout
);

    localparam int TW    = $clog2(TIMEOUT) + 1;
    localparam int DEPTH = 2 ** LOGDEPTH;
    localparam int CW    = LOGDEPTH + 1;
    localparam int EW    = 2 * WIDTH;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        PASS = 2'd1,
        FAIL = 2'd2,
        TOUT = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [EW-1:0]        mem_q [DEPTH];
    logic [EW-1:0]        mem_d [DEPTH];
    logic [LOGDEPTH-1:0]  wr_ptr_q, wr_ptr_d;
    logic [LOGDEPTH-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic [CNTW-1:0]      scnt_q, scnt_d;

    logic hit;
    logic full;
    logic empty;
    logic push;
    logic pop;

    // Verdict FSM; a result store on the last timer cycle beats timeout
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        hit     = memwrite && (adr == EXP_ADR);
        if (state_q == RUN) begin
            timer_d = timer_q + TW'(1);
            if (hit) begin
                state_d = (writedata == EXP_DATA) ? PASS : FAIL;
            end else if (timer_q == TW'(TIMEOUT - 1)) begin
                state_d = TOUT;
            end
        end
    end

    // Store log; a pop on a full FIFO frees the slot for a same-cycle push
    always_comb begin
        full     = (cnt_q == CW'(DEPTH));
        empty    = (cnt_q == '0);
        pop      = log_rd && !empty;
        push     = memwrite && (!full || pop);
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = {adr, writedata};
        end
        wr_ptr_d = wr_ptr_q + LOGDEPTH'(push);
        rd_ptr_d = rd_ptr_q + LOGDEPTH'(pop);
        cnt_d    = cnt_q + CW'(push) - CW'(pop);
        ovf_d    = ovf_q | (memwrite & full & ~pop);
        scnt_d   = scnt_q;
        if (memwrite && (scnt_q != '1)) begin
            scnt_d = scnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= RUN;
            timer_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            scnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            scnt_q   <= scnt_d;
        end
    end

    assign pass         = (state_q == PASS);
    assign fail         = (state_q == FAIL);
    assign timeout      = (state_q == TOUT);
    assign done         = pass | fail | timeout;
    assign log_valid    = !empty;
    assign log_adr      = mem_q[rd_ptr_q][EW-1:WIDTH];
    assign log_data     = mem_q[rd_ptr_q][WIDTH-1:0];
    assign log_overflow = ovf_q;
    assign store_count  = scnt_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// Scoreboard bench for mem_write_checker: expected log entries are queued as
// stores are driven and compared as the FIFO is popped.
module tb_mem_write_checker;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       memwrite = 1'b0;
    logic [7:0] adr = '0;
    logic [7:0] writedata = '0;
    logic       log_rd = 1'b0;
    logic       log_valid;
    logic [7:0] log_adr;
    logic [7:0] log_data;
    logic       log_overflow;
    logic [7:0] store_count;
    logic       done;
    logic       pass;
    logic       fail;
    logic       timeout;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] sb [$];
    int          exp_cnt = 0;
    logic        exp_ovf = 1'b0;

    mem_write_checker dut (
        .clk          (clk),
        .reset        (reset),
        .memwrite     (memwrite),
        .adr          (adr),
        .writedata    (writedata),
        .log_rd       (log_rd),
        .log_valid    (log_valid),
        .log_adr      (log_adr),
        .log_data     (log_data),
        .log_overflow (log_overflow),
        .store_count  (store_count),
        .done         (done),
        .pass         (pass),
        .fail         (fail),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic verdict(input string tag, input logic p, input logic f,
                           input logic t);
        check({tag, ".pass"}, 32'(pass), 32'(p));
        check({tag, ".fail"}, 32'(fail), 32'(f));
        check({tag, ".timeout"}, 32'(timeout), 32'(t));
        check({tag, ".done"}, 32'(done), 32'(p | f | t));
    endtask

    task automatic status(input string tag);
        check({tag, ".count"}, 32'(store_count), 32'(exp_cnt));
        check({tag, ".ovf"}, 32'(log_overflow), 32'(exp_ovf));
    endtask

    task automatic do_store(input logic [7:0] a, input logic [7:0] d);
        memwrite  = 1'b1;
        adr       = a;
        writedata = d;
        if (sb.size() < 4) sb.push_back({a, d});
        else exp_ovf = 1'b1;
        if (exp_cnt < 255) exp_cnt++;
        tick();
        memwrite = 1'b0;
    endtask

    task automatic pop_check(input string tag);
        logic [15:0] e;
        if (sb.size() == 0) begin
            check({tag, ".empty"}, 32'(log_valid), 32'd0);
        end else begin
            e = sb.pop_front();
            check({tag, ".valid"}, 32'(log_valid), 32'd1);
            check({tag, ".entry"}, {16'd0, log_adr, log_data}, {16'd0, e});
        end
        log_rd = 1'b1;
        tick();
        log_rd = 1'b0;
    endtask

    task automatic push_pop(input string tag, input logic [7:0] a,
                            input logic [7:0] d);
        logic [15:0] e;
        e = sb.pop_front();
        check({tag, ".valid"}, 32'(log_valid), 32'd1);
        check({tag, ".head"}, {16'd0, log_adr, log_data}, {16'd0, e});
        sb.push_back({a, d});
        if (exp_cnt < 255) exp_cnt++;
        memwrite  = 1'b1;
        adr       = a;
        writedata = d;
        log_rd    = 1'b1;
        tick();
        memwrite = 1'b0;
        log_rd   = 1'b0;
    endtask

    task automatic drain(input string tag);
        while (sb.size() > 0) pop_check(tag);
        check({tag, ".drained"}, 32'(log_valid), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        sb.delete();
        exp_cnt = 0;
        exp_ovf = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        // Reset held for 3 cycles
        reset = 1'b0;
        idle(3);
        verdict("rst_hold", 0, 0, 0);
        reset = 1'b1;
        idle(5);
        verdict("idle", 0, 0, 0);
        status("idle");
        check("idle.valid", 32'(log_valid), 32'd0);

        // Pass sequence
        do_store(8'h10, 8'h01);
        do_store(8'h11, 8'h02);
        verdict("pre_pass", 0, 0, 0);
        do_store(8'hEE, 8'h0D);
        verdict("pass", 1, 0, 0);
        status("pass");
        drain("pass_log");
        log_rd = 1'b1;
        tick();
        log_rd = 1'b0;
        check("empty_pop", 32'(log_valid), 32'd0);
        verdict("pass_hold", 1, 0, 0);

        // Fail is sticky against a later correct store
        do_reset();
        do_store(8'hEE, 8'h0C);
        verdict("fail", 0, 1, 0);
        do_store(8'hEE, 8'h0D);
        verdict("fail_sticky", 0, 1, 0);
        status("fail");
        drain("fail_log");

        // Timeout exactly 400 edges after release
        do_reset();
        idle(399);
        verdict("pre_tout", 0, 0, 0);
        tick();
        verdict("tout", 0, 0, 1);
        idle(3);
        verdict("tout_hold", 0, 0, 1);

        // Result store on the final timer edge beats timeout
        do_reset();
        idle(399);
        do_store(8'hEE, 8'h0D);
        verdict("late_pass", 1, 0, 0);
        idle(3);
        verdict("late_hold", 1, 0, 0);
        drain("late_log");

        // Fill, push+pop while full, then overflow
        do_reset();
        for (int i = 0; i < 4; i++) do_store(8'h20 + 8'(i), 8'h30 + 8'(i));
        status("full");
        push_pop("pp", 8'h40, 8'h50);
        status("pp");
        do_store(8'h41, 8'h51);
        status("ovf");
        verdict("ovf", 0, 0, 0);
        drain("ovf_log");

        // Async reset while in PASS with a full FIFO
        do_reset();
        do_store(8'h01, 8'h02);
        do_store(8'h03, 8'h04);
        do_store(8'h05, 8'h06);
        do_store(8'hEE, 8'h0D);
        verdict("pre_arst", 1, 0, 0);
        check("pre_arst.valid", 32'(log_valid), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        sb.delete();
        exp_cnt = 0;
        exp_ovf = 1'b0;
        verdict("arst", 0, 0, 0);
        status("arst");
        check("arst.valid", 32'(log_valid), 32'd0);
        @(negedge clk);
        tick();
        reset = 1'b1;
        tick();
        verdict("post_arst", 0, 0, 0);
        status("post_arst");
        check("post_arst.valid", 32'(log_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
